// File: rtl/spi_px_master_pkg.sv
// Shared types and constants for the pixel-link SPI initiator.
// Default frame width mirrors the chip-level pixel width.
package spi_px_master_pkg;

    localparam int DEFAULT_PIXEL_WIDTH = 24;
    localparam int DEFAULT_SCK_DIV     = 4;

    // Mode 0: SCK idles low, data launched on falling edge, sampled on rising edge
    localparam logic SPI_CPOL    = 1'b0;
    localparam logic SPI_CS_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP
    } spi_m_state_e;

endpackage

// File: rtl/spi_px_master_sck_gen.sv
// SCK half-period timer: ticks phase_end on the last clk of every half period.
// Held at zero while restart is high so the first phase after a start is full length.
module spi_sck_gen #(
    parameter int SCK_DIV = 4
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic restart,
    output logic phase_end
);

    localparam int HW = $clog2(SCK_DIV);

    logic [HW-1:0] hc;

    assign phase_end = (hc == HW'(SCK_DIV - 1));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            hc <= '0;
        end else if (restart || phase_end) begin
            hc <= '0;
        end else begin
            hc <= hc + 1'b1;
        end
    end

endmodule

// File: rtl/spi_px_master.sv
// SPI mode-0 initiator: one pixel per CS frame out on SDO, full-duplex return word on rx_px_o.
// All SPI pins come straight from flops; reset forces CS high and SCK low asynchronously.
module spi_px_master
    import spi_px_master_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
    parameter int SCK_DIV     = DEFAULT_SCK_DIV
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic [PIXEL_WIDTH-1:0] tx_px_i,
    input  logic                   tx_valid_i,
    output logic                   tx_ready_o,
    output logic [PIXEL_WIDTH-1:0] rx_px_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic                   busy_o,
    output logic                   spi_sck_o,
    output logic                   spi_cs_o,
    output logic                   spi_sdo_o,
    input  logic                   spi_sdi_i
);

    localparam int BW = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;

    spi_m_state_e           state;
    logic [PIXEL_WIDTH-1:0] tx_sr;
    logic [PIXEL_WIDTH-1:0] rx_sr;
    logic [BW-1:0]          bit_cnt;
    logic                   phase_end;
    logic                   accept;

    // A pending rx word blocks new frames so it can never be overwritten
    assign tx_ready_o = (state == IDLE) && !rx_valid_o;
    assign accept     = tx_valid_i && tx_ready_o;
    assign busy_o     = (state != IDLE);

    spi_sck_gen #(
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .clk_i     (clk_i),
        .nreset_i  (nreset_i),
        .restart   (state == IDLE),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state      <= IDLE;
            spi_cs_o   <= SPI_CS_IDLE;
            spi_sck_o  <= SPI_CPOL;
            spi_sdo_o  <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            rx_px_o    <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        // MSB goes straight to the pin; tx_sr keeps the remaining bits left-aligned
                        tx_sr     <= tx_px_i << 1;
                        spi_sdo_o <= tx_px_i[PIXEL_WIDTH-1];
                        bit_cnt   <= BW'(PIXEL_WIDTH - 1);
                        spi_cs_o  <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        spi_sck_o <= 1'b1;
                        state     <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        rx_sr     <= {rx_sr[PIXEL_WIDTH-2:0], spi_sdi_i};
                        spi_sck_o <= 1'b0;
                        spi_sdo_o <= tx_sr[PIXEL_WIDTH-1];
                        tx_sr     <= tx_sr << 1;
                        state     <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        if (bit_cnt != '0) begin
                            bit_cnt   <= bit_cnt - 1'b1;
                            spi_sck_o <= 1'b1;
                            state     <= SHIFT_HI;
                        end else begin
                            // Last low phase doubles as CS hold time
                            spi_cs_o   <= 1'b1;
                            spi_sdo_o  <= 1'b0;
                            rx_px_o    <= rx_sr;
                            rx_valid_o <= 1'b1;
                            state      <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_px_master.sv
// Bench for spi_px_master: synchronised loop-back responder, tx/rx scoreboards, frame-timing monitor.
module tb_spi_px_master;

    localparam int PW  = 24;
    localparam int DIV = 4;

    logic          clk_i = 1'b0;
    logic          nreset_i = 1'b0;
    logic [PW-1:0] tx_px_i = '0;
    logic          tx_valid_i = 1'b0;
    logic          tx_ready_o;
    logic [PW-1:0] rx_px_o;
    logic          rx_valid_o;
    logic          rx_ready_i = 1'b0;
    logic          busy_o;
    logic          spi_sck_o;
    logic          spi_cs_o;
    logic          spi_sdo_o;
    logic          spi_sdi_i;

    spi_px_master #(.PIXEL_WIDTH(PW), .SCK_DIV(DIV)) dut (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .tx_px_i    (tx_px_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_px_o    (rx_px_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .busy_o     (busy_o),
        .spi_sck_o  (spi_sck_o),
        .spi_cs_o   (spi_cs_o),
        .spi_sdo_o  (spi_sdo_o),
        .spi_sdi_i  (spi_sdi_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] exp_tx[$];
    logic [PW-1:0] exp_rx[$];
    logic [PW-1:0] resp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Responder: word chosen at CS fall is what the master must report afterwards
    function automatic logic [PW-1:0] draw_word();
        logic [PW-1:0] w;
        if (resp_q.size() != 0) w = resp_q.pop_front();
        else                    w = PW'($urandom);
        exp_rx.push_back(w);
        return w;
    endfunction

    logic [2:0]    cs_s  = 3'b111;
    logic [2:0]    sck_s = 3'b000;
    logic [PW-1:0] r_word = '0;
    int unsigned   r_idx = 0;

    always @(negedge clk_i) begin
        cs_s  <= {cs_s[1:0], spi_cs_o};
        sck_s <= {sck_s[1:0], spi_sck_o};
        if (!cs_s[1] && cs_s[2]) begin
            r_word <= draw_word();
            r_idx  <= PW - 1;
        end else if (!cs_s[1] && !sck_s[1] && sck_s[2] && r_idx != 0) begin
            r_idx <= r_idx - 1;
        end
    end

    assign spi_sdi_i = r_word[r_idx];

    int rx_mode = 2;   // 0: always ready, 1: random, 2: held low
    initial forever begin
        @(posedge clk_i);
        #1;
        case (rx_mode)
            0:       rx_ready_i = 1'b1;
            1:       rx_ready_i = ($urandom_range(0, 3) != 0);
            default: rx_ready_i = 1'b0;
        endcase
    end

    // Frame monitor: MOSI word, CS-low length, SCK activity, busy and GAP length
    bit            abort = 1'b0;
    bit            in_frame = 1'b0;
    int            low_cnt = 0;
    int            mon_bits = 0;
    logic [PW-1:0] mon_word = '0;
    bit            busy_bad = 1'b0;
    bit            sck_bad = 1'b0;
    int            hi_run = 0;
    int            last_gap = 0;
    bit            gap_pending = 1'b0;
    int            gap_busy = 0;
    logic          prev_sck = 1'b0;

    initial forever begin
        @(negedge clk_i);
        if (!spi_cs_o) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                low_cnt  = 0;
                mon_bits = 0;
                mon_word = '0;
                busy_bad = 1'b0;
                last_gap = hi_run;
            end
            low_cnt++;
            if (spi_sck_o && !prev_sck) begin
                mon_word = {mon_word[PW-2:0], spi_sdo_o};
                mon_bits++;
            end
            if (!busy_o) busy_bad = 1'b1;
        end else begin
            if (spi_sck_o || prev_sck) sck_bad = 1'b1;
            if (in_frame) begin
                in_frame = 1'b0;
                if (exp_tx.size() == 0) begin
                    chk("tx_queue_underflow", 32'd1, 32'd0);
                end else begin
                    logic [PW-1:0] px;
                    px = exp_tx.pop_front();
                    if (!abort) begin
                        chk("mosi_word", mon_word, px);
                        chk("sck_rising_edges", mon_bits, PW);
                        chk("cs_low_cycles", low_cnt, DIV * (2 * PW + 1));
                        chk("rx_valid_at_cs_rise", rx_valid_o, 1);
                        chk("busy_during_frame", busy_bad, 0);
                        chk("sck_only_with_cs_low", sck_bad, 0);
                    end
                end
                sck_bad     = 1'b0;
                gap_pending = !abort;
                gap_busy    = 0;
                abort       = 1'b0;
                hi_run      = 0;
            end
            hi_run++;
            if (gap_pending) begin
                if (busy_o) gap_busy++;
                else begin
                    chk("gap_busy_cycles", gap_busy, DIV);
                    gap_pending = 1'b0;
                end
            end
        end
        prev_sck = spi_sck_o;
    end

    // rx scoreboard: compare on every accepted rx word
    initial forever begin
        @(negedge clk_i);
        if (nreset_i && rx_valid_o && rx_ready_i) begin
            if (exp_rx.size() == 0) chk("rx_queue_underflow", 32'd1, 32'd0);
            else                    chk("rx_px", rx_px_o, exp_rx.pop_front());
        end
    end

    task automatic send(input logic [PW-1:0] px);
        int n = 0;
        @(posedge clk_i);
        #1;
        tx_px_i    = px;
        tx_valid_i = 1'b1;
        do begin
            @(negedge clk_i);
            n++;
        end while (!tx_ready_o && n < 2000);
        if (n >= 2000) chk("tx_accept_timeout", 32'd1, 32'd0);
        else           exp_tx.push_back(px);
        @(posedge clk_i);
        #1;
        tx_valid_i = 1'b0;
        tx_px_i    = PW'($urandom);
    endtask

    task automatic wait_idle(input string name, input bit want_rx);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((busy_o || rx_valid_o != want_rx) && n < 2000);
        chk(name, (n >= 2000), 0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stall_bad;
        int n;

        repeat (3) @(negedge clk_i);
        chk("reset_cs", spi_cs_o, 1);
        chk("reset_sck", spi_sck_o, 0);
        chk("reset_sdo", spi_sdo_o, 0);
        chk("reset_rx_valid", rx_valid_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_rx_px", rx_px_o, 0);
        nreset_i = 1'b1;
        @(negedge clk_i);
        chk("idle_tx_ready", tx_ready_o, 1);

        // Directed frame, rx left pending
        resp_q.push_back(24'h123456);
        send(24'hA53C0F);
        wait_idle("frame1_done", 1'b1);

        // Pending rx blocks the next pixel
        tx_px_i    = 24'h5A5A5A;
        tx_valid_i = 1'b1;
        stall_bad  = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (tx_ready_o || !spi_cs_o || busy_o || !rx_valid_o) stall_bad = 1'b1;
        end
        chk("stall_no_frame", stall_bad, 0);
        exp_tx.push_back(24'h5A5A5A);
        rx_mode = 0;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(rx_valid_o && rx_ready_i) && n < 20);
        chk("stall_release_timeout", (n >= 20), 0);
        @(negedge clk_i);
        chk("release_tx_ready", tx_ready_o, 1);
        chk("release_cs_still_high", spi_cs_o, 1);
        @(posedge clk_i);
        #1;
        tx_valid_i = 1'b0;
        @(negedge clk_i);
        chk("frame2_cs_low", spi_cs_o, 0);
        wait_idle("frame2_done", 1'b0);

        // Back-to-back frames: GAP plus the accept cycle between CS windows
        for (int i = 0; i < 3; i++) begin
            send(PW'($urandom));
            @(posedge clk_i);
            #1;
            if (i > 0) chk("b2b_cs_high_cycles", last_gap, DIV + 1);
        end
        wait_idle("b2b_done", 1'b0);

        // Reset during bit 10
        send(PW'($urandom));
        n = 0;
        while (mon_bits < 10 && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        chk("bit10_timeout", (n >= 1000), 0);
        @(posedge clk_i);
        #1;
        abort    = 1'b1;
        nreset_i = 1'b0;
        #1;
        chk("midreset_cs", spi_cs_o, 1);
        chk("midreset_sck", spi_sck_o, 0);
        chk("midreset_rx_valid", rx_valid_o, 0);
        chk("midreset_busy", busy_o, 0);
        chk("midreset_rx_px", rx_px_o, 0);
        repeat (3) @(negedge clk_i);
        nreset_i = 1'b1;
        repeat (5) @(negedge clk_i);
        exp_rx.delete();
        resp_q.push_back(24'hC0FFEE);
        send(24'h0F1E2D);
        wait_idle("post_reset_frame", 1'b0);

        // Random pixels, random consumer stalls
        rx_mode = 1;
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
            send(PW'($urandom));
        end
        rx_mode = 0;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((exp_tx.size() != 0 || exp_rx.size() != 0 || busy_o || rx_valid_o) && n < 2000);
        chk("drain_tx_queue", exp_tx.size(), 0);
        chk("drain_rx_queue", exp_rx.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
